// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 UART receiver driven by a 16x oversample strobe.
// smp_clk is synchronised and edge-detected into a one-cycle tick. Each bit is
// decided by a 3-sample majority vote around the bit centre.
// Ports:
//   sys_clk       system clock, all logic on posedge
//   reset         asynchronous active-high reset
//   smp_clk       oversample clock from the generator, sampled as data
//   rx            asynchronous serial line, idle high
//   rx_data       last correctly framed byte
//   rx_valid      one-cycle pulse: rx_data updated
//   rx_frame_err  one-cycle pulse: stop bit sampled low
//   rx_busy       high while the receiver is not idle
module uart_rx_sampler #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned MID        = 8
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 smp_clk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BCNT_W = $clog2(DATA_BITS);
    localparam logic [SCNT_W-1:0] S_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [SCNT_W-1:0] S_A    = SCNT_W'(MID - 1);
    localparam logic [SCNT_W-1:0] S_B    = SCNT_W'(MID);
    localparam logic [SCNT_W-1:0] S_C    = SCNT_W'(MID + 1);
    localparam logic [BCNT_W-1:0] B_LAST = BCNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t                state, state_nx;
    logic [SCNT_W-1:0]     scnt, scnt_nx, scnt_inc;
    logic [BCNT_W-1:0]     bcnt, bcnt_nx;
    logic [DATA_BITS-1:0]  shift, shift_nx, data_nx;
    logic [1:0]            vote, vote_nx;
    logic                  valid_nx, ferr_nx, busy_nx;
    logic                  rx_m, rx_s, smp_m, smp_s, smp_d;
    logic                  tick, counting, at_vote, at_wrap, bit_v;

    // 2-FF synchronisers plus smp_clk rising-edge detector
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            rx_m  <= 1'b1;
            rx_s  <= 1'b1;
            smp_m <= 1'b0;
            smp_s <= 1'b0;
            smp_d <= 1'b0;
        end else begin
            rx_m  <= rx;
            rx_s  <= rx_m;
            smp_m <= smp_clk;
            smp_s <= smp_m;
            smp_d <= smp_s;
        end
    end

    assign tick     = smp_s & ~smp_d;
    assign scnt_inc = scnt + SCNT_W'(1);
    assign counting = (state == START) || (state == DATA) || (state == STOP);
    // Sample points are taken on the post-increment count so the vote lands on ticks 7..9 of the bit
    assign at_vote  = tick && (scnt_inc == S_C);
    assign at_wrap  = tick && (scnt == S_LAST);
    assign bit_v    = (vote[0] & vote[1]) | (vote[0] & rx_s) | (vote[1] & rx_s);

    // Next-state and next-output logic
    always_comb begin
        state_nx = state;
        scnt_nx  = scnt;
        bcnt_nx  = bcnt;
        shift_nx = shift;
        vote_nx  = vote;
        data_nx  = rx_data;
        valid_nx = 1'b0;
        ferr_nx  = 1'b0;

        if (counting && tick) begin
            scnt_nx = scnt_inc;
            if (scnt_inc == S_A) vote_nx[0] = rx_s;
            if (scnt_inc == S_B) vote_nx[1] = rx_s;
        end

        case (state)
            IDLE: begin
                if (tick && !rx_s) begin
                    state_nx = START;
                    scnt_nx  = '0;
                end
            end
            START: begin
                if (at_vote && bit_v) begin
                    state_nx = IDLE;
                end else if (at_wrap) begin
                    state_nx = DATA;
                    bcnt_nx  = '0;
                end
            end
            DATA: begin
                if (at_vote) shift_nx = {bit_v, shift[DATA_BITS-1:1]};
                if (at_wrap) begin
                    if (bcnt == B_LAST) state_nx = STOP;
                    else                bcnt_nx  = bcnt + BCNT_W'(1);
                end
            end
            STOP: begin
                if (at_vote) begin
                    if (bit_v) begin
                        data_nx  = shift;
                        valid_nx = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        ferr_nx  = 1'b1;
                        state_nx = BREAK;
                    end
                end
            end
            BREAK: begin
                // hold until the line is released so a stuck-low line yields one error only
                if (tick && rx_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
    end

    // State and output registers
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            scnt         <= '0;
            bcnt         <= '0;
            shift        <= '0;
            vote         <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            state        <= state_nx;
            scnt         <= scnt_nx;
            bcnt         <= bcnt_nx;
            shift        <= shift_nx;
            vote         <= vote_nx;
            rx_data      <= data_nx;
            rx_valid     <= valid_nx;
            rx_frame_err <= ferr_nx;
            rx_busy      <= busy_nx;
        end
    end

endmodule
